// File: rtl/mod_n_counter.sv
// mod_n_counter: modulo-N up/down counter stage with enable, preset, cascade carry and wrap/error pulses.
// Optional BCD digit outputs TENS/ONES when MODCNT_BCD_EN is defined.
module mod_n_counter #(
    parameter int N = 60,
    parameter int M = 6
) (
    input  logic         CLK,
    input  logic         CLEAR,
    input  logic         EN,
    input  logic         UP,
    input  logic         LOAD,
    input  logic [M-1:0] LOAD_VAL,
    output logic [M-1:0] COUNT,
    output logic         CARRY,
    output logic         OUT,
`ifdef MODCNT_BCD_EN
    output logic         ERR,
    output logic [3:0]   TENS,
    output logic [3:0]   ONES
`else
    output logic         ERR
`endif
);
    localparam logic [M-1:0] TOP = M'(N - 1);
    logic [M-1:0] nxt;
    logic         wrap;
    logic         oor;
    if (N < 2 || N > (2 ** M)) begin : g_bad_n
        $error("mod_n_counter: N out of range for M");
    end
`ifdef MODCNT_BCD_EN
    if (N > 100) begin : g_bad_bcd
        $error("mod_n_counter: BCD output needs N <= 100");
    end
`endif
    // Up-count treats any value at or above TOP as terminal so an illegal state recovers.
    always_comb begin
        oor = LOAD_VAL > TOP;
        wrap = EN & ~LOAD & (UP ? COUNT >= TOP : COUNT == '0);
        CARRY = EN & ~LOAD & ~CLEAR & (UP ? COUNT == TOP : COUNT == '0);
        nxt = LOAD ? (oor ? TOP : LOAD_VAL)
            : !EN ? COUNT
            : UP ? (wrap ? '0 : COUNT + 1'b1)
            : (wrap ? TOP : COUNT - 1'b1);
    end
    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            COUNT <= '0;
            OUT <= 1'b0;
            ERR <= 1'b0;
`ifdef MODCNT_BCD_EN
            TENS <= 4'd0;
            ONES <= 4'd0;
`endif
        end else begin
            COUNT <= nxt;
            OUT <= wrap;
            ERR <= LOAD & oor;
`ifdef MODCNT_BCD_EN
            TENS <= 4'(32'(nxt) / 10);
            ONES <= 4'(32'(nxt) % 10);
`endif
        end
    end
endmodule

// File: tb/tb_mod_n_counter.sv
// tb_mod_n_counter: directed and randomized checks of a seconds/minutes cascade against a modular-arithmetic model.
module tb_mod_n_counter;
    localparam int N = 60;
    logic clk = 1'b0, clear = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [5:0] lval = '0;
    logic min_up = 1'b1, min_load = 1'b0;
    logic [5:0] min_lval = '0;
    logic [5:0] sec_count, min_count;
    logic sec_carry, sec_out, sec_err, min_carry, min_out, min_err;
`ifdef MODCNT_BCD_EN
    logic [3:0] sec_tens, sec_ones, min_tens, min_ones;
`endif
    int n_pass = 0, n_tot = 0;
    int m_cnt = 0, mm_cnt = 0;
    bit m_out = 0, m_err = 0, mm_out = 0, mm_err = 0;

    always #5 clk = ~clk;

    mod_n_counter #(.N(N), .M(6)) u_sec (
        .CLK(clk), .CLEAR(clear), .EN(en), .UP(up), .LOAD(load), .LOAD_VAL(lval),
        .COUNT(sec_count), .CARRY(sec_carry), .OUT(sec_out),
`ifdef MODCNT_BCD_EN
        .TENS(sec_tens), .ONES(sec_ones),
`endif
        .ERR(sec_err)
    );
    mod_n_counter #(.N(N), .M(6)) u_min (
        .CLK(clk), .CLEAR(clear), .EN(sec_carry), .UP(min_up), .LOAD(min_load), .LOAD_VAL(min_lval),
        .COUNT(min_count), .CARRY(min_carry), .OUT(min_out),
`ifdef MODCNT_BCD_EN
        .TENS(min_tens), .ONES(min_ones),
`endif
        .ERR(min_err)
    );

    function automatic bit carry_of(input int c, input bit e, input bit u, input bit l, input bit cl);
        return e && !l && !cl && (u ? c == N - 1 : c == 0);
    endfunction

    function automatic void rule(input int c, input bit cl, input bit l, input bit e, input bit u,
                                 input int lv, output int nc, output bit o, output bit er);
        nc = c;
        o = 0;
        er = 0;
        if (cl) nc = 0;
        else if (l) begin
            nc = lv < N ? lv : N - 1;
            er = lv >= N;
        end else if (e) begin
            o = u ? c == N - 1 : c == 0;
            nc = u ? (c + 1) % N : (c + N - 1) % N;
        end
    endfunction

    task automatic edge_step();
        int nc, mc;
        bit no, ne, mo, me, sc;
        sc = carry_of(m_cnt, en, up, load, clear);
        rule(m_cnt, clear, load, en, up, int'(lval), nc, no, ne);
        rule(mm_cnt, clear, min_load, sc, min_up, int'(min_lval), mc, mo, me);
        @(posedge clk);
        #1;
        m_cnt = nc; m_out = no; m_err = ne;
        mm_cnt = mc; mm_out = mo; mm_err = me;
    endtask

    task automatic test_reset();
        clear = 1; en = 1; up = 0; load = 0;
        edge_step();
        edge_step();
        n_tot++; if (sec_count !== 6'd0) $display("FAIL reset_count got %0d want 0", sec_count); else n_pass++;
        n_tot++; if (sec_out !== 1'b0) $display("FAIL reset_out got %b want 0", sec_out); else n_pass++;
        n_tot++; if (sec_err !== 1'b0) $display("FAIL reset_err got %b want 0", sec_err); else n_pass++;
        n_tot++; if (sec_carry !== 1'b0) $display("FAIL reset_carry got %b want 0", sec_carry); else n_pass++;
        n_tot++; if (min_count !== 6'd0) $display("FAIL reset_min_count got %0d want 0", min_count); else n_pass++;
`ifdef MODCNT_BCD_EN
        n_tot++; if ({sec_tens, sec_ones} !== 8'h00) $display("FAIL reset_bcd got %h want 00", {sec_tens, sec_ones}); else n_pass++;
`endif
        clear = 0; en = 0; up = 1;
    endtask

    task automatic test_up_wrap();
        en = 1; up = 1;
        for (int i = 0; i < 60; i++) begin
            #1;
            n_tot++; if (sec_count !== 6'(i)) $display("FAIL up_count got %0d want %0d", sec_count, i); else n_pass++;
            n_tot++; if (sec_carry !== (i == 59)) $display("FAIL up_carry at %0d got %b want %b", i, sec_carry, i == 59); else n_pass++;
            edge_step();
            n_tot++; if (sec_out !== (i == 59)) $display("FAIL up_out at %0d got %b want %b", i, sec_out, i == 59); else n_pass++;
        end
        n_tot++; if (sec_count !== 6'd0) $display("FAIL up_wrap_count got %0d want 0", sec_count); else n_pass++;
        n_tot++; if (mm_cnt != 1 || min_count !== 6'd1) $display("FAIL up_min_inc got %0d want 1", min_count); else n_pass++;
        en = 0;
        edge_step();
        n_tot++; if (sec_out !== 1'b0) $display("FAIL up_out_onecycle got %b want 0", sec_out); else n_pass++;
    endtask

    task automatic test_down_wrap();
        en = 1; up = 0;
        #1;
        n_tot++; if (sec_carry !== 1'b1) $display("FAIL down_carry got %b want 1", sec_carry); else n_pass++;
        edge_step();
        n_tot++; if (sec_count !== 6'd59) $display("FAIL down_wrap_count got %0d want 59", sec_count); else n_pass++;
        n_tot++; if (sec_out !== 1'b1) $display("FAIL down_wrap_out got %b want 1", sec_out); else n_pass++;
        edge_step();
        n_tot++; if (sec_count !== 6'd58) $display("FAIL down_next_count got %0d want 58", sec_count); else n_pass++;
        n_tot++; if (sec_out !== 1'b0) $display("FAIL down_next_out got %b want 0", sec_out); else n_pass++;
        en = 0; up = 1;
    endtask

    task automatic test_preset();
        load = 1; lval = 45;
        edge_step();
        n_tot++; if (sec_count !== 6'd45 || sec_err !== 1'b0) $display("FAIL preset_45 got %0d/%b want 45/0", sec_count, sec_err); else n_pass++;
        lval = 63;
        edge_step();
        n_tot++; if (sec_count !== 6'd59 || sec_err !== 1'b1) $display("FAIL preset_63 got %0d/%b want 59/1", sec_count, sec_err); else n_pass++;
        lval = 60;
        edge_step();
        n_tot++; if (sec_count !== 6'd59 || sec_err !== 1'b1) $display("FAIL preset_60 got %0d/%b want 59/1", sec_count, sec_err); else n_pass++;
        lval = 59;
        edge_step();
        n_tot++; if (sec_count !== 6'd59 || sec_err !== 1'b0) $display("FAIL preset_59 got %0d/%b want 59/0", sec_count, sec_err); else n_pass++;
        en = 1; up = 1; lval = 10;
        #1;
        n_tot++; if (sec_carry !== 1'b0) $display("FAIL preset_carry got %b want 0", sec_carry); else n_pass++;
        edge_step();
        n_tot++; if (sec_count !== 6'd10 || sec_out !== 1'b0) $display("FAIL preset_over_wrap got %0d/%b want 10/0", sec_count, sec_out); else n_pass++;
        load = 0;
        edge_step();
        n_tot++; if (sec_count !== 6'd11 || sec_err !== 1'b0) $display("FAIL preset_resume got %0d/%b want 11/0", sec_count, sec_err); else n_pass++;
        en = 0;
    endtask

    task automatic test_cascade();
        load = 1; lval = 59; min_load = 1; min_lval = 0;
        edge_step();
        load = 0; min_load = 0; en = 1; up = 1; min_up = 1;
        #1;
        n_tot++; if (sec_carry !== 1'b1) $display("FAIL cascade_carry got %b want 1", sec_carry); else n_pass++;
        edge_step();
        n_tot++; if (min_count !== 6'd1 || sec_count !== 6'd0) $display("FAIL cascade_time got %0d:%0d want 1:0", min_count, sec_count); else n_pass++;
        en = 0;
    endtask

    task automatic test_clear_mid_wrap();
        load = 1; lval = 59;
        edge_step();
        load = 0; en = 1; clear = 1;
        edge_step();
        n_tot++; if (sec_count !== 6'd0 || sec_out !== 1'b0) $display("FAIL clear_wrap got %0d/%b want 0/0", sec_count, sec_out); else n_pass++;
        clear = 0; en = 0;
    endtask

`ifdef MODCNT_BCD_EN
    task automatic test_bcd();
        load = 1; lval = 37;
        edge_step();
        n_tot++; if (sec_count !== 6'd37 || sec_tens !== 4'd3 || sec_ones !== 4'd7) $display("FAIL bcd_37 got %0d %0d%0d want 37 37", sec_count, sec_tens, sec_ones); else n_pass++;
        load = 0; en = 1; up = 1;
        repeat (22) edge_step();
        n_tot++; if (sec_tens !== 4'd5 || sec_ones !== 4'd9) $display("FAIL bcd_59 got %0d%0d want 59", sec_tens, sec_ones); else n_pass++;
        edge_step();
        n_tot++; if (sec_tens !== 4'd0 || sec_ones !== 4'd0) $display("FAIL bcd_wrap got %0d%0d want 00", sec_tens, sec_ones); else n_pass++;
        en = 0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            clear = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 7) == 0);
            lval = 6'($urandom_range(0, 63));
            en = ($urandom_range(0, 3) != 0);
            up = ($urandom_range(0, 3) != 0);
            min_load = ($urandom_range(0, 15) == 0);
            min_lval = 6'($urandom_range(0, 63));
            min_up = ($urandom_range(0, 1) == 1);
            #1;
            n_tot++; if (sec_carry !== carry_of(m_cnt, en, up, load, clear)) $display("FAIL rnd_sec_carry cyc %0d got %b want %b", i, sec_carry, carry_of(m_cnt, en, up, load, clear)); else n_pass++;
            n_tot++; if (min_carry !== carry_of(mm_cnt, sec_carry, min_up, min_load, clear)) $display("FAIL rnd_min_carry cyc %0d got %b", i, min_carry); else n_pass++;
            edge_step();
            n_tot++; if ({sec_count, sec_out, sec_err} !== {6'(m_cnt), m_out, m_err}) $display("FAIL rnd_sec cyc %0d got %0d/%b/%b want %0d/%b/%b", i, sec_count, sec_out, sec_err, m_cnt, m_out, m_err); else n_pass++;
            n_tot++; if ({min_count, min_out, min_err} !== {6'(mm_cnt), mm_out, mm_err}) $display("FAIL rnd_min cyc %0d got %0d/%b/%b want %0d/%b/%b", i, min_count, min_out, min_err, mm_cnt, mm_out, mm_err); else n_pass++;
`ifdef MODCNT_BCD_EN
            n_tot++; if ({sec_tens, sec_ones} !== {4'(m_cnt / 10), 4'(m_cnt % 10)}) $display("FAIL rnd_bcd cyc %0d got %0d%0d want %0d", i, sec_tens, sec_ones, m_cnt); else n_pass++;
`endif
        end
        clear = 0; load = 0; min_load = 0; en = 0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_preset();
        test_cascade();
        test_clear_mid_wrap();
`ifdef MODCNT_BCD_EN
        test_bcd();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
